// File: rtl/simon_pkg.sv
// Shared SIMON definitions: z constant sequences, round constant and key-unschedule FSM states.
package simon_pkg;

  typedef enum logic [1:0] {IDLE, EMIT, DONE_P} state_t;

  // Bit 0 of each sequence is the leftmost digit, i.e. literal bit 61.
  localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [61:0] Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
  localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
  localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
  localparam logic [61:0] Z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;

  function automatic logic z_select(input int sel, input logic [5:0] idx);
    logic [61:0] z;
    case (sel)
      0: z = Z0;
      1: z = Z1;
      2: z = Z2;
      3: z = Z3;
      default: z = Z4;
    endcase
    return z[6'd61 - idx];
  endfunction

  // {n-2 ones, 2'b00}, right-aligned in 64 bits.
  function automatic logic [63:0] round_const(input int n);
    return ((64'd1 << n) - 64'd1) & ~64'd3;
  endfunction

endpackage

// File: rtl/right_shifter.sv
// Fixed right rotation of one word by SHIFT_COUNT bits; pure wiring, no latency.
module right_shifter #(
  parameter int WORD_SIZE   = 16,
  parameter int SHIFT_COUNT = 1
) (
  input  logic [WORD_SIZE-1:0] word,
  output logic [WORD_SIZE-1:0] rotated
);

  assign rotated = {word[SHIFT_COUNT-1:0], word[WORD_SIZE-1:SHIFT_COUNT]};

endmodule

// File: rtl/simon_key_unschd.sv
// Reverse SIMON key schedule: streams k[T-1]..k[0] from the last m forward round keys.
// First key one cycle after start; valid/ready handshake, one key per cycle, output holds while stalled.
module simon_key_unschd
  import simon_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int KEY_WORDS = 4,
  parameter int ROUNDS    = 32,
  parameter int Z_SEQ     = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [KEY_WORDS*WORD_SIZE-1:0]  last_keys,
  output logic                            busy,
  output logic                            key_valid,
  input  logic                            key_ready,
  output logic [WORD_SIZE-1:0]            key_out,
  output logic [7:0]                      key_idx,
  output logic                            done
);

  localparam logic [63:0]          C_FULL   = round_const(WORD_SIZE);
  localparam logic [WORD_SIZE-1:0] C        = C_FULL[WORD_SIZE-1:0];
  localparam logic [7:0]           LAST_IDX = 8'(ROUNDS - 1);
  localparam logic [7:0]           M_IDX    = 8'(KEY_WORDS);
  localparam logic [5:0]           Z_INIT   = 6'((ROUNDS - KEY_WORDS - 1) % 62);

  // win[j] holds k[i+1+j] where i is the next key to regenerate.
  logic [WORD_SIZE-1:0] win [KEY_WORDS];
  state_t               state;
  logic [7:0]           out_idx;
  logic [5:0]           zcnt;

  logic [WORD_SIZE-1:0] ror3;
  logic [WORD_SIZE-1:0] ror1;
  logic [WORD_SIZE-1:0] tmp_a;
  logic [WORD_SIZE-1:0] tmp_b;
  logic [WORD_SIZE-1:0] gen;
  logic                 gen_ok;
  logic                 xfer;

  right_shifter #(.WORD_SIZE(WORD_SIZE), .SHIFT_COUNT(3)) u_ror3 (
    .word    (win[KEY_WORDS-2]),
    .rotated (ror3)
  );

  right_shifter #(.WORD_SIZE(WORD_SIZE), .SHIFT_COUNT(1)) u_ror1 (
    .word    (tmp_a),
    .rotated (ror1)
  );

  always_comb begin
    tmp_a  = ror3 ^ ((KEY_WORDS == 4) ? win[0] : '0);
    tmp_b  = tmp_a ^ ror1;
    gen    = win[KEY_WORDS-1] ^ C ^ {{(WORD_SIZE-1){1'b0}}, z_select(Z_SEQ, zcnt)} ^ tmp_b;
    gen_ok = (out_idx >= M_IDX);
    xfer   = key_valid & key_ready;
  end

  assign key_out = win[KEY_WORDS-1];
  assign key_idx = out_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_idx   <= 8'd0;
      zcnt      <= 6'd0;
      busy      <= 1'b0;
      key_valid <= 1'b0;
      done      <= 1'b0;
      for (int k = 0; k < KEY_WORDS; k++) win[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            for (int k = 0; k < KEY_WORDS; k++)
              win[k] <= last_keys[k*WORD_SIZE +: WORD_SIZE];
            out_idx   <= LAST_IDX;
            zcnt      <= Z_INIT;
            busy      <= 1'b1;
            key_valid <= 1'b1;
            state     <= EMIT;
          end
        end
        EMIT: begin
          if (xfer) begin
            if (out_idx == 8'd0) begin
              key_valid <= 1'b0;
              done      <= 1'b1;
              state     <= DONE_P;
            end else begin
              for (int k = KEY_WORDS - 1; k > 0; k--) win[k] <= win[k-1];
              out_idx <= out_idx - 8'd1;
              // Once fewer than m keys remain, the window already holds them all.
              if (gen_ok) begin
                win[0] <= gen;
                zcnt   <= (zcnt == 6'd0) ? 6'd61 : zcnt - 6'd1;
              end else begin
                win[0] <= '0;
              end
            end
          end
        end
        DONE_P: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          key_valid <= 1'b0;
          done      <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simon_key_unschd.sv
// Bench for simon_key_unschd: four builds streamed against a forward key-schedule model.
module tb_simon_key_unschd;

  localparam int NW [4] = '{16, 32, 48, 64};
  localparam int MW [4] = '{4, 3, 2, 2};
  localparam int TR [4] = '{32, 42, 52, 72};
  localparam int ZS [4] = '{0, 2, 2, 2};

  string zstr [5] = '{
    "11111010001001010110000111001101111101000100101011000011100110",
    "10001110111110010011000010110101000111011111001001100001011010",
    "10101111011100000011010010011000101000010001111110010110110011",
    "11011011101011000110010111100000010010001010011100110100001111",
    "11010001111001101011011000100000010111000011001010010011101111"};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  start, rdy, vld, dn, bsy;
  logic [255:0] lk [4];
  logic [7:0]  kidx [4];
  logic [63:0] kout [4];
  logic [15:0] ko_a;
  logic [31:0] ko_b;
  logic [47:0] ko_c;
  logic [63:0] ko_d;
  logic [63:0] ks [4][80];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign kout[0] = {48'd0, ko_a};
  assign kout[1] = {32'd0, ko_b};
  assign kout[2] = {16'd0, ko_c};
  assign kout[3] = ko_d;

  simon_key_unschd #(.WORD_SIZE(16), .KEY_WORDS(4), .ROUNDS(32), .Z_SEQ(0)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .last_keys(lk[0][63:0]), .busy(bsy[0]),
    .key_valid(vld[0]), .key_ready(rdy[0]), .key_out(ko_a), .key_idx(kidx[0]), .done(dn[0]));
  simon_key_unschd #(.WORD_SIZE(32), .KEY_WORDS(3), .ROUNDS(42), .Z_SEQ(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .last_keys(lk[1][95:0]), .busy(bsy[1]),
    .key_valid(vld[1]), .key_ready(rdy[1]), .key_out(ko_b), .key_idx(kidx[1]), .done(dn[1]));
  simon_key_unschd #(.WORD_SIZE(48), .KEY_WORDS(2), .ROUNDS(52), .Z_SEQ(2)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .last_keys(lk[2][95:0]), .busy(bsy[2]),
    .key_valid(vld[2]), .key_ready(rdy[2]), .key_out(ko_c), .key_idx(kidx[2]), .done(dn[2]));
  simon_key_unschd #(.WORD_SIZE(64), .KEY_WORDS(2), .ROUNDS(72), .Z_SEQ(2)) u_d (
    .clk(clk), .rst_n(rst_n), .start(start[3]), .last_keys(lk[3][127:0]), .busy(bsy[3]),
    .key_valid(vld[3]), .key_ready(rdy[3]), .key_out(ko_d), .key_idx(kidx[3]), .done(dn[3]));

  function automatic logic [63:0] wmask(input int n);
    return (n == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << n) - 64'd1);
  endfunction

  function automatic logic [63:0] ror(input logic [63:0] x, input int r, input int n);
    return ((x >> r) | (x << (n - r))) & wmask(n);
  endfunction

  function automatic logic [15:0] rol16(input logic [15:0] v, input int r);
    return (v << r) | (v >> (16 - r));
  endfunction

  // Forward SIMON key expansion from the key words already placed in ks[d][0..m-1].
  task automatic build_model(input int d);
    int n, m;
    logic [63:0] tmp, zb;
    string s;
    n = NW[d]; m = MW[d];
    s = zstr[ZS[d]];
    for (int i = 0; i < TR[d] - m; i++) begin
      tmp = ror(ks[d][i+m-1], 3, n);
      if (m == 4) tmp = tmp ^ ks[d][i+1];
      tmp = tmp ^ ror(tmp, 1, n);
      zb = (s.getc(i % 62) == 8'h31) ? 64'd1 : 64'd0;
      ks[d][i+m] = (wmask(n) & ~64'd3) ^ zb ^ ks[d][i] ^ tmp;
    end
  endtask

  task automatic test_model_vector;
    logic [15:0] x, y, tt;
    x = 16'h6565; y = 16'h6877;
    for (int i = 0; i < 32; i++) begin
      tt = x;
      x = y ^ ((rol16(x, 1) & rol16(x, 8)) ^ rol16(x, 2)) ^ ks[0][i][15:0];
      y = tt;
    end
    total++;
    if ({x, y} !== 32'hc69be9bb) begin
      bad++;
      $display("FAIL model_simon32_ct got=%h want=c69be9bb", {x, y});
    end
  endtask

  task automatic test_reset;
    #12;
    for (int d = 0; d < 4; d++) begin
      total++;
      if (vld[d] !== 1'b0 || bsy[d] !== 1'b0 || dn[d] !== 1'b0 || kout[d] !== 64'd0 || kidx[d] !== 8'd0) begin
        bad++;
        $display("FAIL reset_state dut=%0d got vld=%b busy=%b done=%b key=%h idx=%0d want all 0",
                 d, vld[d], bsy[d], dn[d], kout[d], kidx[d]);
      end
    end
    @(negedge clk); rst_n = 1'b1;
    rdy = 4'hF;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      total++;
      if (vld[d] !== 1'b0 || bsy[d] !== 1'b0 || kidx[d] !== 8'd0) begin
        bad++;
        $display("FAIL ready_idle dut=%0d got vld=%b busy=%b idx=%0d want 0 0 0", d, vld[d], bsy[d], kidx[d]);
      end
    end
    rdy = 4'h0;
  endtask

  // mode 0: ready always high; mode 1: random ready. special 1: start at idx 20; 2: reset at idx 10.
  task automatic run_stream(input int d, input int mode, input int special);
    int n, m, t, e, cyc;
    logic r, stalled;
    logic [63:0] pk;
    logic [7:0] pidx;
    logic [255:0] pack;
    logic [15:0] kw_a [4];
    kw_a[0] = 16'h0100; kw_a[1] = 16'h0908; kw_a[2] = 16'h1110; kw_a[3] = 16'h1918;
    n = NW[d]; m = MW[d]; t = TR[d];
    pack = '0;
    for (int j = m - 1; j >= 0; j--) pack = (pack << n) | 256'(ks[d][t-m+j]);
    lk[d] = pack;
    @(negedge clk);
    total++;
    if (vld[d] !== 1'b0) begin bad++; $display("FAIL pre_start_valid dut=%0d got=%b want=0", d, vld[d]); end
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    total++;
    if (vld[d] !== 1'b1 || bsy[d] !== 1'b1) begin
      bad++; $display("FAIL start_latency dut=%0d got vld=%b busy=%b want 1 1", d, vld[d], bsy[d]);
    end
    e = t - 1; cyc = 0; stalled = 1'b0; pk = '0; pidx = '0;
    while (e >= 0 && cyc < 4000) begin
      total++;
      if (vld[d] !== 1'b1 || dn[d] !== 1'b0) begin
        bad++; $display("FAIL stream_valid dut=%0d e=%0d got vld=%b done=%b want 1 0", d, e, vld[d], dn[d]);
      end
      total++;
      if (kout[d] !== ks[d][e] || kidx[d] !== 8'(e)) begin
        bad++;
        $display("FAIL key_seq dut=%0d got key=%h idx=%0d want key=%h idx=%0d", d, kout[d], kidx[d], ks[d][e], e);
      end
      if (stalled) begin
        total++;
        if (kout[d] !== pk || kidx[d] !== pidx) begin
          bad++; $display("FAIL stall_hold dut=%0d got key=%h idx=%0d want key=%h idx=%0d", d, kout[d], kidx[d], pk, pidx);
        end
      end
      if (d == 0 && e < 4) begin
        total++;
        if (kout[d][15:0] !== kw_a[e]) begin
          bad++; $display("FAIL key_word dut=0 idx=%0d got=%h want=%h", e, kout[d][15:0], kw_a[e]);
        end
      end
      if (special == 2 && e == 10) begin
        rdy[d] = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (vld[d] !== 1'b0 || bsy[d] !== 1'b0 || dn[d] !== 1'b0 || kout[d] !== 64'd0 || kidx[d] !== 8'd0) begin
          bad++;
          $display("FAIL async_reset dut=%0d got vld=%b busy=%b done=%b key=%h idx=%0d want all 0",
                   d, vld[d], bsy[d], dn[d], kout[d], kidx[d]);
        end
        repeat (2) begin
          @(negedge clk);
          total++;
          if (dn[d] !== 1'b0 || vld[d] !== 1'b0) begin
            bad++; $display("FAIL reset_hold dut=%0d got done=%b vld=%b want 0 0", d, dn[d], vld[d]);
          end
        end
        rst_n = 1'b1;
        return;
      end
      if (special == 1 && e == 20) begin
        start[d] = 1'b1;
        lk[d] = {8{$urandom}};
      end
      r = (mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
      rdy[d] = r; pk = kout[d]; pidx = kidx[d];
      @(posedge clk);
      @(negedge clk);
      start[d] = 1'b0;
      if (r) e--;
      stalled = !r;
      cyc++;
    end
    rdy[d] = 1'b0;
    if (e >= 0) begin
      total++; bad++;
      $display("FAIL stream_timeout dut=%0d stuck at e=%0d after %0d cycles", d, e, cyc);
    end
    total++;
    if (dn[d] !== 1'b1 || vld[d] !== 1'b0) begin
      bad++; $display("FAIL done_pulse dut=%0d got done=%b vld=%b want 1 0", d, dn[d], vld[d]);
    end
    @(negedge clk);
    total++;
    if (dn[d] !== 1'b0 || bsy[d] !== 1'b0) begin
      bad++; $display("FAIL done_end dut=%0d got done=%b busy=%b want 0 0", d, dn[d], bsy[d]);
    end
  endtask

  task automatic test_stream;        run_stream(0, 0, 0); endtask
  task automatic test_backpressure;  run_stream(0, 1, 0); run_stream(0, 1, 0); endtask
  task automatic test_key_words;     run_stream(1, 0, 0); run_stream(1, 1, 0); run_stream(2, 0, 0); run_stream(2, 1, 0); endtask
  task automatic test_mid_start;     run_stream(0, 0, 1); run_stream(0, 1, 1); endtask
  task automatic test_reset_mid;     run_stream(0, 0, 2); run_stream(0, 0, 0); endtask
  task automatic test_wide;          run_stream(3, 0, 0); run_stream(3, 1, 0); endtask

  initial begin
    rst_n = 1'b0; start = '0; rdy = '0;
    for (int d = 0; d < 4; d++) lk[d] = '0;
    ks[0][0] = 64'h0100; ks[0][1] = 64'h0908; ks[0][2] = 64'h1110; ks[0][3] = 64'h1918;
    for (int d = 1; d < 4; d++)
      for (int j = 0; j < MW[d]; j++) ks[d][j] = {$urandom, $urandom} & wmask(NW[d]);
    for (int d = 0; d < 4; d++) build_model(d);
    test_reset();
    test_model_vector();
    test_stream();
    test_backpressure();
    test_key_words();
    test_mid_start();
    test_reset_mid();
    test_wide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
